alu_issue: RTL and testbench

//  Decode/operand-fetch stage directly upstream of the 8-bit ALU. Accepts 16-bit

---
 rtl/octa_pkg.sv | 48 ++++
 rtl/alu_issue_regfile_8x8.sv | 27 ++
 rtl/alu_issue.sv | 83 ++++++++
 tb/tb_alu_issue.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/octa_pkg.sv
// Shared encodings and instruction layout for the ALU issue stage.
package octa_pkg;
  localparam int DW   = 8;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int IW   = 16;

  typedef enum logic [2:0] {
    CTRL_ADD   = 3'b000,
    CTRL_LOGIC = 3'b001,
    CTRL_SLTU  = 3'b010,
    CTRL_SHIFT = 3'b011,
    CTRL_SRA   = 3'b100
  } ctrl_e;

  localparam int CTRL_LSB = 13;
  localparam int FLAG_BIT = 12;
  localparam int RD_LSB   = 9;
  localparam int RS1_LSB  = 6;
  localparam int IMM_BIT  = 5;
  localparam int RS2_LSB  = 2;

  typedef struct packed {
    logic [2:0]    ctrl;
    logic          flag;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic          imm_sel;
    logic [AW-1:0] rs2;
    logic [4:0]    imm5;
  } dec_t;

  function automatic dec_t decode(input logic [IW-1:0] ins);
    dec_t d;
    d.ctrl    = ins[CTRL_LSB +: 3];
    d.flag    = ins[FLAG_BIT];
    d.rd      = ins[RD_LSB +: AW];
    d.rs1     = ins[RS1_LSB +: AW];
    d.imm_sel = ins[IMM_BIT];
    d.rs2     = ins[RS2_LSB +: AW];
    d.imm5    = ins[4:0];
    return d;
  endfunction

  function automatic logic ctrl_legal(input logic [2:0] c);
    return c <= CTRL_SRA;
  endfunction
endpackage

// File: rtl/alu_issue_regfile_8x8.sv
// 8x8 register file: two async read ports with write-back bypass, one sync write, r0 hardwired 0.
module regfile_8x8
  import octa_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0][AW-1:0]       ra,
  output logic [1:0][DW-1:0]       rdata,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [DW-1:0]            wd
);
  logic [NREG-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                mem_q <= '0;
    else if (we && wa != '0)   mem_q[wa] <= wd;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata[p] = mem_q[ra[p]];
      if (ra[p] == '0)                rdata[p] = '0;
      else if (we && wa == ra[p])     rdata[p] = wd;
    end
  end
endmodule

// File: rtl/alu_issue.sv
// Decode/operand-fetch stage: scoreboard hazard check, bypassed operand read, registered ALU issue.
module alu_issue
  import octa_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [2:0]     out_ctrl,
  output logic           out_flag,
  output logic [AW-1:0]  out_rd,
  input  logic           wb_en,
  input  logic [AW-1:0]  wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic           illegal_op
);
  dec_t                  dec;
  logic [1:0][DW-1:0]    rdata;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  haz1, haz2, hazard, accept, legal;
  logic [DW-1:0]         opb;

  assign dec = decode(in_instr);

  regfile_8x8 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra    ({dec.rs2, dec.rs1}),
    .rdata (rdata),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  // A write-back landing this cycle resolves the hazard through the bypass.
  assign haz1   = busy_q[dec.rs1] && !(wb_en && wb_addr == dec.rs1);
  assign haz2   = !dec.imm_sel && busy_q[dec.rs2] && !(wb_en && wb_addr == dec.rs2);
  assign hazard = haz1 || haz2;

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign legal    = ctrl_legal(dec.ctrl);
  assign opb      = dec.imm_sel ? {{(DW-5){1'b0}}, dec.imm5} : rdata[1];

  // Set after clear so an issue to the register being written back keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && wb_addr != '0)            busy_d[wb_addr] = 1'b0;
    if (accept && legal && dec.rd != '0)   busy_d[dec.rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_ctrl   <= '0;
      out_flag   <= 1'b0;
      out_rd     <= '0;
      illegal_op <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      illegal_op <= accept && !legal;
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_a     <= rdata[0];
        out_b     <= opb;
        out_ctrl  <= dec.ctrl;
        out_flag  <= dec.flag;
        out_rd    <= dec.rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: write-back, hazards, stall, illegal op, immediates, reset.
module tb_alu_issue;
  import octa_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic [IW-1:0]  in_instr;
  logic           out_valid, out_ready;
  logic [DW-1:0]  out_a, out_b;
  logic [2:0]     out_ctrl;
  logic           out_flag;
  logic [AW-1:0]  out_rd;
  logic           wb_en;
  logic [AW-1:0]  wb_addr;
  logic [DW-1:0]  wb_data;
  logic           illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_flag(out_flag), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [2:0] c, input logic f, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {c, f, rd, rs1, 1'b0, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] ri(input logic [2:0] c, input logic f, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [4:0] imm);
    return {c, f, rd, rs1, 1'b1, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_instr = '0; out_ready = 1; wb_en = 0; wb_addr = '0; wb_data = '0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_illegal", {31'd0, illegal_op}, 0);
    check("rst_out_a", {24'd0, out_a}, 0);
    check("rst_busy", {24'd0, dut.busy_q}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;

    // 1: write r1, r2 then issue ADD r3,r1,r2
    tick(); wb_en = 1; wb_addr = 3'd1; wb_data = 8'h12;
    tick(); wb_addr = 3'd2; wb_data = 8'h34;
    tick(); wb_en = 0; in_valid = 1; in_instr = rr(3'b000, 1'b0, 3'd3, 3'd1, 3'd2);
    check("t1_in_ready", {31'd0, in_ready}, 1);
    tick();
    check("t1_out_valid", {31'd0, out_valid}, 1);
    check("t1_out_a", {24'd0, out_a}, 32'h12);
    check("t1_out_b", {24'd0, out_b}, 32'h34);
    check("t1_ctrl", {29'd0, out_ctrl}, 0);
    check("t1_rd", {29'd0, out_rd}, 3);
    check("t1_busy", {24'd0, dut.busy_q}, 32'h08);

    // 2: dependent on r3 -> stall, then accept with same-cycle bypass
    in_instr = rr(3'b000, 1'b1, 3'd4, 3'd3, 3'd1);
    #1 check("t2_hazard_ready", {31'd0, in_ready}, 0);
    tick();
    check("t2_drained", {31'd0, out_valid}, 0);
    wb_en = 1; wb_addr = 3'd3; wb_data = 8'h46;
    #1 check("t2_bypass_ready", {31'd0, in_ready}, 1);
    tick(); wb_en = 0;
    check("t2_out_valid", {31'd0, out_valid}, 1);
    check("t2_out_a", {24'd0, out_a}, 32'h46);
    check("t2_out_b", {24'd0, out_b}, 32'h12);
    check("t2_flag", {31'd0, out_flag}, 1);
    check("t2_rd", {29'd0, out_rd}, 4);
    check("t2_busy", {24'd0, dut.busy_q}, 32'h10);

    // 3: backpressure for 3 cycles, then release
    out_ready = 0; in_instr = rr(3'b000, 1'b0, 3'd5, 3'd1, 3'd2);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall_ready", {31'd0, in_ready}, 0);
      tick();
      check("t3_hold_valid", {31'd0, out_valid}, 1);
      check("t3_hold_a", {24'd0, out_a}, 32'h46);
      check("t3_hold_rd", {29'd0, out_rd}, 4);
    end
    out_ready = 1;
    #1 check("t3_release_ready", {31'd0, in_ready}, 1);
    tick();
    check("t3_next_a", {24'd0, out_a}, 32'h12);
    check("t3_next_rd", {29'd0, out_rd}, 5);
    check("t3_busy", {24'd0, dut.busy_q}, 32'h30);

    // 4: illegal ctrl consumed without issue
    in_instr = rr(3'b110, 1'b0, 3'd6, 3'd1, 3'd2);
    tick();
    check("t4_illegal", {31'd0, illegal_op}, 1);
    check("t4_no_valid", {31'd0, out_valid}, 0);
    check("t4_busy", {24'd0, dut.busy_q}, 32'h30);
    in_valid = 0;
    tick();
    check("t4_pulse_end", {31'd0, illegal_op}, 0);

    // 5: write to r0 ignored, then immediate with rs1=r0
    wb_en = 1; wb_addr = 3'd0; wb_data = 8'hFF;
    tick(); wb_en = 0;
    check("t5_busy_r0wb", {24'd0, dut.busy_q}, 32'h30);
    in_valid = 1; in_instr = ri(3'b001, 1'b0, 3'd7, 3'd0, 5'h1F);
    tick();
    check("t5_out_a", {24'd0, out_a}, 0);
    check("t5_out_b", {24'd0, out_b}, 32'h1F);
    check("t5_ctrl", {29'd0, out_ctrl}, 1);
    check("t5_busy", {24'd0, dut.busy_q}, 32'hB0);

    // 6: async reset while output pending and busy[5] set
    in_valid = 0; out_ready = 0;
    #1 rst_n = 0;
    #1;
    check("t6_valid", {31'd0, out_valid}, 0);
    check("t6_busy", {24'd0, dut.busy_q}, 0);
    check("t6_out_b", {24'd0, out_b}, 0);
    rst_n = 1; out_ready = 1;
    tick();
    in_valid = 1; in_instr = rr(3'b000, 1'b0, 3'd3, 3'd1, 3'd2);
    #1 check("t6_ready", {31'd0, in_ready}, 1);
    tick(); in_valid = 0;
    check("t6_reissue_valid", {31'd0, out_valid}, 1);
    check("t6_regs_zero_a", {24'd0, out_a}, 0);
    check("t6_regs_zero_b", {24'd0, out_b}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
